appmult_dot_accum: RTL and testbench
====================================

// Module: appmult_dot_accum
// PURPOSE
//  Streaming dot-product engine wrapped around the combinational 7x7 unsigned approximate multiplier.
//  Accepts operand pairs over a valid/ready stream and registers them onto the multiplier operand ports.
//  Registers the returned product, accumulates it, and emits one sum per vector (delimited by in_last).
//  Used by the retraining hardware-in-loop flow to evaluate approximate MAC results per neuron.
// PARAMETERS
//  W_IN   7   operand width (unsigned), matches multiplier input width
//  W_P    14  product width returned by multiplier (2*W_IN)
//  ACC_W  24  accumulator/result width; arithmetic is modulo 2^ACC_W
//  CNT_W  10  element-counter width; counter saturates at 2^CNT_W-1
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       operand pair valid
//  in_ready   out  1       engine can accept a pair this cycle
//  in_a       in   W_IN    operand A
//  in_b       in   W_IN    operand B
//  in_last    in   1       pair is final element of current vector
//  mult_a     out  W_IN    to multiplier IN1 (driven from S1 register)
//  mult_b     out  W_IN    to multiplier IN2 (driven from S1 register)
//  mult_p     in   W_P     from multiplier Out (combinational from mult_a/mult_b)
//  res_valid  out  1       result valid
//  res_ready  in   1       downstream accepts result
//  res_sum    out  ACC_W   vector sum of approximate products
//  res_cnt    out  CNT_W   number of elements in vector
//  res_ovf    out  1       sticky: accumulator carried out of ACC_W during this vector
// BEHAVIOUR
//  - Global enable: en = !(res_valid && !res_ready). Condition in_ready = en.
//    Handshake occurs when in_valid && in_ready.
//  - S1 (on en): a_q <= in_a, b_q <= in_b, last1 <= in_last, v1 <= in_valid && in_ready.
//    mult_a = a_q, mult_b = b_q.
//  - S2 (on en): p_q <= mult_p, last2 <= last1, v2 <= v1. Multiplier path is 1 full cycle, S1 reg to S2 reg.
//  - S3 (on en, v2=1): sum = acc + p_q (ACC_W+1 bits).
//    last2=0: acc <= sum[ACC_W-1:0], cnt++ (saturating), ovf |= sum[ACC_W].
//    last2=1: res_sum <= sum[ACC_W-1:0], res_cnt <= cnt+1 (sat), res_ovf <= ovf|sum[ACC_W],
//      res_valid <= 1, acc/cnt/ovf <= 0.
//  - res_valid clears on res_valid && res_ready unless a new last2 result loads the same cycle (load wins).
//  - Latency: handshake in cycle c with in_last=1 -> res_valid high from cycle c+3.
//    Throughput 1 pair/cycle while unstalled.
//  - Stall (en=0): S1, S2, S3, acc and mult_a/mult_b hold. mult_p stays consistent, so no product is lost or duplicated.
//  - Bubbles (v=0) pass without touching acc/cnt.
//  - A single-element vector (in_last on first pair) gives res_sum = product, res_cnt = 1.
//  - Reset: all valids, acc, cnt, ovf, res_* = 0; a_q = b_q = 0, so mult_a = mult_b = 0.
//    in_ready = 1 in the first cycle after reset. Reset mid-vector discards the partial sum and any in-flight pairs.
//  - in_a/in_b/in_last may change freely when no handshake occurs. No X on outputs after reset.
// STRUCTURE
//  - Shared package appmult_pkg: W_IN, W_P, ACC_W, CNT_W localparams;
//    typedef struct {logic [W_IN-1:0] a, b; logic last;} op_pair_t; typedef logic [ACC_W-1:0] acc_t.
//  - One sub-module appmult_acc_core: S3 accumulator + result register + res handshake.
//    The top holds S1/S2 and en. The multiplier is instantiated outside this block.
// TESTING (bench models mult_p = mult_a*mult_b exact unless stated)
//  1. Reset, then pairs (3,4),(5,6),(7,8,last), res_ready=1 -> res_sum=98, res_cnt=3, res_ovf=0, res_valid 3 cycles after last pair.
//  2. Single pair (127,127,last) -> res_sum=16129, res_cnt=1; the next vector's sum starts from 0.
//  3. Back-to-back vectors, 1 pair/cycle, res_ready low 5 cycles on first result ->
//     in_ready low exactly while held; second result correct, nothing dropped.
//  4. Set ACC_W=14; 2 pairs (127,127) last -> res_sum=32258 mod 16384=15874, res_ovf=1;
//     the following vector has res_ovf=0.
//  5. Assert rst mid-vector after 2 pairs, then send (2,2,last) -> res_sum=4, res_cnt=1.
//  6. Connect the approximate 7x7 netlist; random 10k vectors of length 1..64 ->
//     results match the golden model built on the same netlist, with random res_ready/in_valid gaps.

Source files
------------

// File: rtl/appmult_pkg.sv
// Shared widths and types for the approximate-multiplier dot-product engine.
// Imported by the stream front end and the accumulator core.
package appmult_pkg;

    localparam int W_IN  = 7;
    localparam int W_P   = 2 * W_IN;
    localparam int ACC_W = 24;
    localparam int CNT_W = 10;

    typedef struct packed {
        logic [W_IN-1:0] a;
        logic [W_IN-1:0] b;
        logic            last;
    } op_pair_t;

    typedef logic [ACC_W-1:0] acc_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // Element counts stick at all-ones instead of wrapping.
    function automatic cnt_t cnt_sat_inc(input cnt_t c);
        return (c == '1) ? c : c + cnt_t'(1);
    endfunction

endpackage

// File: rtl/appmult_acc_core.sv
// Product accumulator with a one-deep result register and its
// valid/ready handshake; one result per vector.
module appmult_acc_core
    import appmult_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             v2,
    input  logic             last2,
    input  logic [W_P-1:0]   p_q,
    input  logic             res_ready,
    output logic             res_valid,
    output logic [ACC_W-1:0] res_sum,
    output logic [CNT_W-1:0] res_cnt,
    output logic             res_ovf
);

    acc_t           acc;
    cnt_t           cnt;
    logic           ovf;
    logic [ACC_W:0] sum;
    logic           take;

    assign take = en && v2;
    assign sum  = {1'b0, acc} + {{(ACC_W + 1 - W_P){1'b0}}, p_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_cnt   <= '0;
            res_ovf   <= 1'b0;
        end else begin
            if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
            // A closing element loads a fresh result, overriding the clear.
            if (take) begin
                if (last2) begin
                    res_sum   <= sum[ACC_W-1:0];
                    res_cnt   <= cnt_sat_inc(cnt);
                    res_ovf   <= ovf | sum[ACC_W];
                    res_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                    ovf       <= 1'b0;
                end else begin
                    acc <= sum[ACC_W-1:0];
                    cnt <= cnt_sat_inc(cnt);
                    ovf <= ovf | sum[ACC_W];
                end
            end
        end
    end

endmodule

// File: rtl/appmult_dot_accum.sv
// Streaming dot-product engine around an external combinational 7x7
// approximate multiplier: operand register, product register, accumulator.
module appmult_dot_accum
    import appmult_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_IN-1:0]  in_a,
    input  logic [W_IN-1:0]  in_b,
    input  logic             in_last,
    output logic [W_IN-1:0]  mult_a,
    output logic [W_IN-1:0]  mult_b,
    input  logic [W_P-1:0]   mult_p,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_sum,
    output logic [CNT_W-1:0] res_cnt,
    output logic             res_ovf
);

    op_pair_t       s1_q;
    logic           v1;
    logic [W_P-1:0] p_q;
    logic           last2;
    logic           v2;
    logic           en;

    // The whole pipe freezes while a finished result waits downstream,
    // so the multiplier inputs hold and mult_p stays matched to S1.
    assign en       = !(res_valid && !res_ready);
    assign in_ready = en;
    assign mult_a   = s1_q.a;
    assign mult_b   = s1_q.b;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            v1   <= 1'b0;
        end else if (en) begin
            s1_q <= '{a: in_a, b: in_b, last: in_last};
            v1   <= in_valid && in_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q   <= '0;
            last2 <= 1'b0;
            v2    <= 1'b0;
        end else if (en) begin
            p_q   <= mult_p;
            last2 <= s1_q.last;
            v2    <= v1;
        end
    end

    appmult_acc_core u_core (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .v2        (v2),
        .last2     (last2),
        .p_q       (p_q),
        .res_ready (res_ready),
        .res_valid (res_valid),
        .res_sum   (res_sum),
        .res_cnt   (res_cnt),
        .res_ovf   (res_ovf)
    );

endmodule

// File: tb/tb_appmult_dot_accum.sv
// Scoreboard bench for appmult_dot_accum with an exact multiplier model
// and a whole-vector arithmetic reference.
module tb_appmult_dot_accum;
    import appmult_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W_IN-1:0]  in_a = '0;
    logic [W_IN-1:0]  in_b = '0;
    logic             in_last = 1'b0;
    logic [W_IN-1:0]  mult_a;
    logic [W_IN-1:0]  mult_b;
    logic [W_P-1:0]   mult_p;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic [ACC_W-1:0] res_sum;
    logic [CNT_W-1:0] res_cnt;
    logic             res_ovf;

    always #5 clk = ~clk;

    assign mult_p = W_P'(mult_a) * W_P'(mult_b);

    appmult_dot_accum dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .mult_a    (mult_a),
        .mult_b    (mult_b),
        .mult_p    (mult_p),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cnt   (res_cnt),
        .res_ovf   (res_ovf)
    );

    typedef struct {
        longint sum;
        longint cnt;
        longint ovf;
    } exp_t;

    exp_t   q[$];
    int     n_checks = 0;
    int     n_pass = 0;
    bit     started = 0;
    longint cur_tot = 0;
    longint cur_n = 0;
    int     rr_mode = 0;
    bit     stall_mode = 0;
    int     held = 0;
    int     stall_low = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s: got none expected event", name);
    endtask

    task automatic record(input int a, input int b, input bit l);
        exp_t   e;
        longint lim;
        lim = longint'(1) << ACC_W;
        cur_tot += longint'(a * b);
        cur_n++;
        if (l) begin
            e.sum = cur_tot % lim;
            e.cnt = (cur_n > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : cur_n;
            e.ovf = (cur_tot >= lim) ? 1 : 0;
            q.push_back(e);
            cur_tot = 0;
            cur_n = 0;
        end
    endtask

    task automatic cyc(input bit v, input int a, input int b, input bit l,
                       output bit hs);
        @(negedge clk);
        in_valid = v;
        in_a = W_IN'(a);
        in_b = W_IN'(b);
        in_last = l;
        if (stall_mode) res_ready = (held >= 5);
        else if (rr_mode == 1) res_ready = ($urandom_range(0, 3) != 0);
        else res_ready = 1'b1;
        #1;
        if (stall_mode && res_valid && !res_ready) held++;
        if (stall_mode && !in_ready) stall_low++;
        hs = v && in_ready && !rst;
        if (hs) record(a, b, l);
    endtask

    task automatic idle();
        bit hs;
        cyc(1'b0, int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
            bit'($urandom_range(0, 1)), hs);
    endtask

    task automatic send(input int a, input int b, input bit l);
        bit hs;
        int tries;
        tries = 0;
        do begin
            cyc(1'b1, a, b, l, hs);
            tries++;
        end while (!hs && tries < 200);
        if (!hs) fail("send_timeout");
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 2000) begin
            idle();
            k++;
        end
        if (q.size() != 0) fail("drain_timeout");
        repeat (2) idle();
    endtask

    // Monitor: pops one expectation per accepted result.
    initial begin
        exp_t e;
        wait (started);
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                chk("in_ready_rule", longint'(in_ready),
                    longint'(!(res_valid && !res_ready)));
                if (res_valid === 1'b1 && res_ready) begin
                    if (q.size() == 0) begin
                        fail("unexpected_result");
                    end else begin
                        e = q.pop_front();
                        chk("res_sum", longint'(res_sum), e.sum);
                        chk("res_cnt", longint'(res_cnt), e.cnt);
                        chk("res_ovf", longint'(res_ovf), e.ovf);
                    end
                end
            end
        end
    end

    initial begin
        int lat;
        int len;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_res_valid", longint'(res_valid), 0);
        chk("rst_res_sum", longint'(res_sum), 0);
        chk("rst_res_cnt", longint'(res_cnt), 0);
        chk("rst_res_ovf", longint'(res_ovf), 0);
        chk("rst_mult_a", longint'(mult_a), 0);
        chk("rst_mult_b", longint'(mult_b), 0);
        started = 1;

        send(3, 4, 0);
        send(5, 6, 0);
        send(7, 8, 1);
        lat = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            idle();
            if (res_valid) lat = k;
        end
        chk("latency", lat, 3);
        drain();

        send(127, 127, 1);
        drain();

        stall_mode = 1;
        held = 0;
        stall_low = 0;
        send(1, 2, 0);
        send(3, 4, 1);
        send(5, 6, 0);
        send(7, 8, 0);
        send(9, 10, 1);
        repeat (8) idle();
        stall_mode = 0;
        chk("stall_held", held, 5);
        chk("stall_in_ready_low", stall_low, 5);
        drain();

        for (int i = 0; i < 1040; i++) send(127, 127, 0);
        send(127, 127, 1);
        send(1, 1, 1);
        drain();

        send(9, 9, 0);
        send(9, 9, 0);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cur_tot = 0;
        cur_n = 0;
        #1;
        chk("midrst_in_ready", longint'(in_ready), 1);
        chk("midrst_res_valid", longint'(res_valid), 0);
        send(2, 2, 1);
        drain();

        rr_mode = 1;
        for (int v = 0; v < 200; v++) begin
            len = $urandom_range(1, 64);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) idle();
                send(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
                     i == len - 1);
            end
        end
        rr_mode = 0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
